// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer:
// FSM state encoding, register operation select codes and default sizes.
package usr_pkg;

  localparam int USR_WIDTH = 4;
  localparam int USR_DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TX_SHIFT = 2'd1,
    ST_RX_SHIFT = 2'd2,
    ST_RX_DONE  = 2'd3
  } usr_state_e;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_SHR  = 2'd1;
  localparam logic [1:0] SEL_SHL  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  // LSB-first traffic moves toward bit 0 (right shift), MSB-first toward the top.
  function automatic logic [1:0] shift_sel(input logic lsb_first);
    return lsb_first ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/usr_bit_timer.sv
// Bit-period pacing for the sequencer: a reloading down-counter that strobes
// o_bit_end on the last cycle of every bit period, plus a bit counter that
// flags the final bit of the word. The divider value is captured on i_start
// so later cfg changes do not disturb a word in flight.
module usr_bit_timer
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int DIV_W = USR_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_bit_end,
  output logic             o_last_bit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DIV_W-1:0] r_div_lat;
  logic [DIV_W-1:0] r_div_cnt;
  logic [CW-1:0]    r_bit_cnt;

  assign o_bit_end  = i_en && (r_div_cnt == '0);
  assign o_last_bit = (r_bit_cnt == CW'(WIDTH - 1));

  // Load on grant, count down each enabled cycle, reload at terminal count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_lat <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (i_start) begin
      r_div_lat <= i_cfg_div;
      r_div_cnt <= i_cfg_div;
      r_bit_cnt <= '0;
    end else if (o_bit_end) begin
      r_div_cnt <= r_div_lat;
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end else if (i_en) begin
      r_div_cnt <= r_div_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Sequencer/arbiter for the 4-bit universal shift register datapath.
// Shares the register between a transmit client (parallel in, serial out)
// and a receive client (serial in, parallel out), pacing each bit with a
// programmable divider. Define USR_SEQ_RX_EN to build the receive path and
// round-robin arbitration; without it the block is transmit-only.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | register free; arbitrate, load TX word on a TX grant
// ST_TX_SHIFT | driving ser_out, shifting once per bit period
// ST_RX_SHIFT | sampling line into register once per bit period
// ST_RX_DONE  | received word presented, waiting for rx_ready
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int DIV_W = USR_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_lsb_first,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_p_din,
  input  logic [WIDTH-1:0] sr_p_dout,
  output logic             ser_out,
  output logic             ser_oe
);

  usr_state_e r_state;
  usr_state_e w_state_nxt;
  logic       r_lsb_first;
  logic       w_start;
  logic       w_en;
  logic       w_bit_end;
  logic       w_last_bit;
  logic       w_tx_win;
  logic       w_rx_win;
  logic [1:0] w_shift_sel;

  usr_bit_timer #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_en       (w_en),
    .i_cfg_div  (cfg_div),
    .o_bit_end  (w_bit_end),
    .o_last_bit (w_last_bit)
  );

  assign w_shift_sel = shift_sel(r_lsb_first);
  assign busy        = (r_state != ST_IDLE);
  assign ser_out     = r_lsb_first ? sr_p_dout[0] : sr_p_dout[WIDTH-1];

`ifdef USR_SEQ_RX_EN
  logic r_ptr_rx;

  // Arbitration: a lone requester wins; on a tie the pointer picks
  always_comb begin
    w_tx_win = 1'b0;
    w_rx_win = 1'b0;
    if (rst_n && (r_state == ST_IDLE)) begin
      w_tx_win = tx_valid && (!rx_req || !r_ptr_rx);
      w_rx_win = rx_req && !w_tx_win;
    end
  end

  // Round-robin pointer: after a grant, the other requester gets the next tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr_rx <= 1'b0;
    end else if (w_tx_win) begin
      r_ptr_rx <= 1'b1;
    end else if (w_rx_win) begin
      r_ptr_rx <= 1'b0;
    end
  end

  assign rx_data = sr_p_dout;
`else
  logic w_unused;

  assign w_unused = ^{rx_req, rx_ready, sr_p_dout};
  assign w_tx_win = rst_n && (r_state == ST_IDLE) && tx_valid;
  assign w_rx_win = 1'b0;
  assign rx_data  = '0;
`endif

  // State register and bit order captured at grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lsb_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_lsb_first <= cfg_lsb_first;
      end
    end
  end

  // Next state and register control; every output holds its idle value unless a state drives it
  always_comb begin
    w_state_nxt = r_state;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    sr_select   = SEL_HOLD;
    sr_p_din    = '0;
    ser_oe      = 1'b0;
    w_start     = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_win) begin
          tx_ready    = 1'b1;
          sr_select   = SEL_LOAD;
          sr_p_din    = tx_data;
          w_start     = 1'b1;
          w_state_nxt = ST_TX_SHIFT;
        end else if (w_rx_win) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RX_SHIFT;
        end
      end
      ST_TX_SHIFT: begin
        ser_oe = 1'b1;
        w_en   = 1'b1;
        if (w_bit_end) begin
          // The last bit is already on ser_out, so no trailing shift
          if (w_last_bit) begin
            w_state_nxt = ST_IDLE;
          end else begin
            sr_select = w_shift_sel;
          end
        end
      end
`ifdef USR_SEQ_RX_EN
      ST_RX_SHIFT: begin
        w_en = 1'b1;
        if (w_bit_end) begin
          sr_select = w_shift_sel;
          if (w_last_bit) begin
            w_state_nxt = ST_RX_DONE;
          end
        end
      end
      ST_RX_DONE: begin
        rx_valid = 1'b1;
        if (rx_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: a behavioural 4-bit universal shift register sits on
// the datapath side; a transaction-level model predicts every output each cycle
// and directed scenarios pin the model with literal expectations.
module tb_usr_seq_ctrl;

  localparam int W = 4;
`ifdef USR_SEQ_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_TX   = 1;
  localparam int M_RX   = 2;
  localparam int M_DONE = 3;

  logic         clk;
  logic         rst_n;
  logic [7:0]   cfg_div;
  logic         cfg_lsb_first;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic         rx_req;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] rx_data;
  logic         busy;
  logic [1:0]   sr_select;
  logic [W-1:0] sr_p_din;
  logic [W-1:0] sr_p_dout;
  logic         ser_out;
  logic         ser_oe;
  logic         line;
  logic [W-1:0] r_sr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  usr_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_div       (cfg_div),
    .cfg_lsb_first (cfg_lsb_first),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_req        (rx_req),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .busy          (busy),
    .sr_select     (sr_select),
    .sr_p_din      (sr_p_din),
    .sr_p_dout     (sr_p_dout),
    .ser_out       (ser_out),
    .ser_oe        (ser_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register on the datapath; both serial inputs tied to the line
  assign sr_p_dout = r_sr;
  always @(posedge clk) begin
    if (!rst_n) r_sr <= '0;
    else begin
      case (sr_select)
        2'd1: r_sr <= {line, r_sr[W-1:1]};
        2'd2: r_sr <= {r_sr[W-2:0], line};
        2'd3: r_sr <= sr_p_din;
        default: r_sr <= r_sr;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model state ----------------
  int           m_mode = M_IDLE;
  int           m_k, m_d, p, idx;
  bit           m_lsb, m_ptr_rx;
  logic [W-1:0] m_word, m_rxw;
  bit           m_samp [W];
  logic         e_txr, e_rxv, e_busy, e_oe, e_ser, tx_win, rx_win;
  logic [1:0]   e_sel, e_shift;
  logic [W-1:0] e_pdin, e_rxd;

  // ---------------- monitor state used by directed checks ----------------
  int           oe_cnt, txr_cnt, busy_cnt, rxv_cnt, rxv_cyc, grant_cyc, grant_n;
  logic [31:0]  oe_log;
  logic [2:0]   grant_log;
  logic         prev_busy = 1'b0, prev_txr = 1'b0, prev_rxv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("tx_ready_in_reset", tx_ready, 1'b0);
      m_mode   = M_IDLE;
      m_ptr_rx = 1'b0;
    end else begin
      p       = m_d + 1;
      e_shift = m_lsb ? 2'd1 : 2'd2;
      e_txr = 0; e_rxv = 0; e_oe = 0; e_ser = 0; e_sel = 2'd0; e_pdin = '0;
      e_busy = (m_mode != M_IDLE);
      e_rxd  = RX_EN ? r_sr : '0;
      tx_win = 0; rx_win = 0;
      case (m_mode)
        M_IDLE: begin
          tx_win = tx_valid && (!RX_EN || !rx_req || !m_ptr_rx);
          rx_win = RX_EN && rx_req && !tx_win;
          e_txr  = tx_win;
          e_sel  = tx_win ? 2'd3 : 2'd0;
          e_pdin = tx_win ? tx_data : '0;
        end
        M_TX: begin
          e_oe  = 1;
          idx   = (m_k - 1) / p;
          e_ser = m_lsb ? m_word[idx] : m_word[W-1-idx];
          e_sel = ((m_k % p) == 0 && m_k < W * p) ? e_shift : 2'd0;
        end
        M_RX: e_sel = ((m_k % p) == 0) ? e_shift : 2'd0;
        default: begin
          e_rxv = 1;
          e_rxd = m_rxw;
        end
      endcase
      chk("tx_ready", tx_ready, e_txr);
      chk("rx_valid", rx_valid, e_rxv);
      chk("busy", busy, e_busy);
      chk("ser_oe", ser_oe, e_oe);
      chk("sr_select", sr_select, e_sel);
      chk("sr_p_din", sr_p_din, e_pdin);
      chk("rx_data", rx_data, e_rxd);
      if (m_mode == M_TX) chk("ser_out", ser_out, e_ser);
      // advance the model across the coming clock edge
      case (m_mode)
        M_IDLE: begin
          if (tx_win) begin
            m_mode = M_TX; m_k = 1; m_d = cfg_div; m_lsb = cfg_lsb_first;
            m_word = tx_data; m_ptr_rx = 1;
          end else if (rx_win) begin
            m_mode = M_RX; m_k = 1; m_d = cfg_div; m_lsb = cfg_lsb_first;
            m_ptr_rx = 0;
          end
        end
        M_TX: if (m_k == W * p) m_mode = M_IDLE; else m_k++;
        M_RX: begin
          if ((m_k % p) == 0) m_samp[m_k / p - 1] = line;
          if (m_k == W * p) begin
            for (int j = 0; j < W; j++) begin
              if (m_lsb) m_rxw[j] = m_samp[j];
              else       m_rxw[W-1-j] = m_samp[j];
            end
            m_mode = M_DONE;
          end else m_k++;
        end
        default: if (rx_ready) m_mode = M_IDLE;
      endcase
      // monitor
      if (ser_oe) begin oe_cnt++; oe_log = {oe_log[30:0], ser_out}; end
      if (tx_ready) txr_cnt++;
      if (busy) busy_cnt++;
      if (rx_valid) rxv_cnt++;
      if (rx_valid && !prev_rxv) rxv_cyc = cyc;
      if (busy && !prev_busy) grant_cyc = cyc - 1;
      if (tx_ready) begin
        if (grant_n < 3) grant_log[2-grant_n] = 1'b1;
        grant_n++;
      end else if (busy && !prev_busy && !prev_txr) begin
        if (grant_n < 3) grant_log[2-grant_n] = 1'b0;
        grant_n++;
      end
    end
    prev_busy = rst_n && busy;
    prev_txr  = rst_n && tx_ready;
    prev_rxv  = rst_n && rx_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    oe_cnt = 0; txr_cnt = 0; busy_cnt = 0; rxv_cnt = 0; oe_log = '0;
  endtask

  task automatic send_tx(input int d, input bit lsb, input logic [W-1:0] data);
    bit got;
    got = 0;
    clr_mon();
    cfg_div = 8'(d); cfg_lsb_first = lsb; tx_data = data; tx_valid = 1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (tx_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("tx_grant_seen", got, 1'b1);
    step();
    tx_valid = 0;
    repeat (W * (d + 1) + 2) step();
  endtask

  task automatic rx_word(input int d, input bit lsb, input logic [W-1:0] bits,
                         input logic [W-1:0] exp_w, input int exp_lat,
                         input int hold, input bit with_tx);
`ifdef USR_SEQ_RX_EN
    bit seen;
`else
    int unused_sink;
`endif
    clr_mon();
    cfg_div = 8'(d); cfg_lsb_first = lsb; rx_req = 1; rx_ready = 0; line = bits[0];
    step();
    rx_req = 0;
    for (int j = 0; j < W; j++) begin
      line = bits[j];
      repeat (d + 1) step();
    end
    line = 0;
`ifdef USR_SEQ_RX_EN
    seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("rx_valid_seen", seen, 1'b1);
    chk("rx_latency", rxv_cyc - grant_cyc, exp_lat);
    chk("rx_word", rx_data, exp_w);
    step();
    if (with_tx) begin
      tx_valid = 1; tx_data = 4'b0011; cfg_div = 0; cfg_lsb_first = 1;
    end
    txr_cnt = 0;
    repeat (hold) step();
    chk("rx_hold_no_tx_ready", txr_cnt, 0);
    chk("rx_word_held", rx_data, exp_w);
    rx_ready = 1;
    step();
    rx_ready = 0;
    if (with_tx) begin
      @(negedge clk);
      chk("tx_after_handshake", tx_ready, 1'b1);
      step();
      tx_valid = 0;
    end
    repeat (8) step();
`else
    unused_sink = exp_lat + hold + int'(with_tx) + int'(exp_w);
    repeat (4) step();
    chk("rx_disabled_no_valid", rxv_cnt, 0);
    chk("rx_disabled_idle", busy_cnt, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; cfg_div = 0; cfg_lsb_first = 0; tx_valid = 0; tx_data = '0;
    rx_req = 0; rx_ready = 0; line = 0; grant_n = 0; grant_log = '0;
    rxv_cyc = 0; grant_cyc = 0;
    clr_mon();
    repeat (3) step();
    rst_n = 1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ser_oe", ser_oe, 1'b0);
    chk("rst_sr_select", sr_select, 2'd0);
    chk("rst_sr_p_din", sr_p_din, 4'd0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 4'd0);
    step();

    // TX LSB first, 3 cycles per bit
    send_tx(2, 1, 4'b1011);
    chk("t1_oe_cycles", oe_cnt, 12);
    chk("t1_tx_ready_cycles", txr_cnt, 1);
    chk("t1_bits", oe_log[11:0], 12'b111111000111);

    // TX MSB first, one bit per cycle
    send_tx(0, 0, 4'b1011);
    chk("t2_bits", oe_log[3:0], 4'b1011);
    chk("t2_oe_cycles", oe_cnt, 4);
    chk("t2_busy_cycles", busy_cnt, 4);

    // RX LSB first, line 0,1,1,0; then MSB first with a stalled handshake
    rx_word(1, 1, 4'b0110, 4'b0110, 9, 0, 0);
    rx_word(0, 0, 4'b1011, 4'b1101, 5, 5, 1);
    repeat (4) step();

    // Both requesting after reset: TX, RX, TX
    rst_n = 0;
    step();
    rst_n = 1;
    grant_n = 0; grant_log = '0;
    cfg_div = 0; cfg_lsb_first = 1; tx_data = 4'b0101;
    tx_valid = 1; rx_req = 1; rx_ready = 1;
    repeat (14) step();
    tx_valid = 0; rx_req = 0; rx_ready = 0;
    repeat (8) step();
    chk("arb_grant_count", grant_n >= 3, 1'b1);
    chk("arb_order", grant_log, RX_EN ? 3'b101 : 3'b111);

    // Reset during the second TX bit, then a full word
    cfg_div = 1; cfg_lsb_first = 1; tx_data = 4'b1001; tx_valid = 1;
    step();
    tx_valid = 0;
    repeat (2) step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_ser_oe", ser_oe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_sr_select", sr_select, 2'd0);
    step();
    send_tx(1, 1, 4'b0110);
    chk("t6_bits", oe_log[7:0], 8'b00111100);
    chk("t6_oe_cycles", oe_cnt, 8);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      tx_valid      = ($urandom_range(0, 3) == 0);
      tx_data       = W'($urandom);
      rx_req        = ($urandom_range(0, 3) == 0);
      rx_ready      = 1'($urandom_range(0, 1));
      line          = 1'($urandom_range(0, 1));
      cfg_div       = 8'($urandom_range(0, 4));
      cfg_lsb_first = 1'($urandom_range(0, 1));
      step();
    end
    rst_n = 1; tx_valid = 0; rx_req = 0; rx_ready = 1; line = 0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Sequencer and arbiter for the 4-bit universal shift register datapath. It drives the register's operation select and parallel-load word. It shares the single register between a transmit requester (parallel word in, serial bits out) and a receive requester (serial bits in, parallel word out), and paces every bit with a programmable clock divider. It sits between the parallel-side client logic and the register instance at the serial-link top level.

## Interface
- WIDTH, 4: register width in bits; must equal the datapath register width.
- DIV_W, 8: width of the bit-period divider configuration.

- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- cfg_div  input  DIV_W  bit period minus one, in clk cycles; sampled at grant
- cfg_lsb_first  input  1  1: LSB first (right shifts); 0: MSB first (left shifts); sampled at grant
- tx_valid  input  1  transmit word offered
- tx_ready  output  1  transmit word accepted this cycle
- tx_data  input  WIDTH  word to transmit
- rx_req  input  1  receive request (level)
- rx_valid  output  1  received word available
- rx_ready  input  1  client accepts received word
- rx_data  output  WIDTH  received word
- busy  output  1  state is not IDLE
- sr_select  output  2  register op: 0 hold, 1 right shift (serial-in enters bit WIDTH-1), 2 left shift (serial-in enters bit 0), 3 parallel load
- sr_p_din  output  WIDTH  register parallel-load value
- sr_p_dout  input  WIDTH  register contents
- ser_out  output  1  transmit bit: sr_p_dout[0] when LSB first, sr_p_dout[WIDTH-1] otherwise
- ser_oe  output  1  transmit line enable

## Operation
- FSM states: IDLE, TX_SHIFT, RX_SHIFT, RX_DONE.
- Registers: grant direction and divider value latched at grant; bit counter 0..WIDTH-1; divider counter; round-robin pointer.
- IDLE, arbitration:
  - TX only pending: TX wins.
  - RX only pending: RX wins.
  - Both pending: pointer decides. Reset value favours TX; the pointer flips to the other requester after each grant.
- TX grant (IDLE):
  - tx_ready=1 combinationally.
  - sr_select=3, sr_p_din=tx_data.
  - Next state TX_SHIFT, bit counter 0, divider cleared.
- TX_SHIFT:
  - ser_oe=1.
  - Each bit is held cfg_div+1 cycles.
  - End of bit period with bit counter < WIDTH-1: sr_select=1 (LSB first) or 2 (MSB first); bit counter increments.
  - End of the last bit: no shift; next state IDLE.
- RX grant (IDLE): next state RX_SHIFT, counters cleared; sr_select=0.
- RX_SHIFT: at the end of each bit period, issue one shift (1 for LSB first, 2 for MSB first). After the WIDTH-th shift, next state RX_DONE.
  - The top level ties both register serial inputs to the line input.
- RX_DONE:
  - rx_valid=1, rx_data=sr_p_dout.
  - sr_select=0, so the word is held stable.
  - rx_valid && rx_ready: next state IDLE.
- Inputs tx_valid and rx_req are ignored outside IDLE; tx_ready stays 0.
- sr_select=0 in every cycle not listed above.
- Reset values: state IDLE, sr_select=0, sr_p_din=0, ser_oe=0, tx_ready=0, rx_valid=0, rx_data=sr_p_dout (register also resets to 0), busy=0, pointer=TX.

## Timing
- Transmit:
  - Load occurs at the tx_ready edge.
  - First bit appears on ser_out the next cycle.
  - ser_oe is high exactly WIDTH*(cfg_div+1) cycles.
  - IDLE is re-entered the cycle after; a new grant is possible in that cycle.
- Receive:
  - First sample edge is cfg_div+1 cycles after the grant edge.
  - rx_valid asserts the cycle after the last shift.
  - Minimum grant-to-rx_valid is WIDTH*(cfg_div+1)+1 cycles.
- cfg_div=0: one bit per cycle, a shift every cycle; this rate must work.
- cfg_div changes mid-operation have no effect until the next grant.
- Reset asserted mid-operation: all outputs take their reset values on the next edge; the partial word is discarded; no tx_ready or rx_valid pulse.

## Configuration
- USR_SEQ_RX_EN:
  - Defined: receive path and arbitration as specified.
  - Undefined: RX_SHIFT and RX_DONE are removed, rx_req is ignored, rx_valid=0 and rx_data=0 permanently, the pointer is removed, and TX is always granted.
- Port list is identical in both builds.

## Structure
- Shared package usr_pkg:
  - State enum.
  - Select encoding constants SEL_HOLD=0, SEL_SHR=1, SEL_SHL=2, SEL_LOAD=3.
  - Default WIDTH.
- One sub-module, usr_bit_timer: divider plus bit counter.
  - Inputs: start, cfg_div.
  - Outputs: bit_end strobe and last_bit flag.
- The register itself is instantiated by the top level, not inside this block.

## Test plan
- TX LSB first, cfg_div=2, tx_data=4'b1011: ser_out 1,1,0,1, each bit for 3 cycles; ser_oe high 12 cycles; tx_ready high 1 cycle.
- TX MSB first, cfg_div=0, tx_data=4'b1011: ser_out 1,0,1,1 on consecutive cycles; busy high 4 cycles.
- RX LSB first, cfg_div=1, line bits 0,1,1,0: rx_data=4'b0110 with rx_valid 9 cycles after grant.
- rx_ready held low 5 cycles in RX_DONE: rx_valid and rx_data stable; a concurrent tx_valid sees no tx_ready until after the handshake.
- tx_valid and rx_req both high after reset: TX served first, then RX. Both high again: TX served.
- rst_n low during the second TX bit: next cycle ser_oe=0, busy=0, sr_select=0; a following tx_valid transmits its full word.
